// File: rtl/snd_dac_if.sv
// Sound DAC bus: sample/mute requests toward the DAC, modulator stream
// and observation signals back from it.
interface snd_dac_if;
  logic [6:0] snd;
  logic       mute;
  logic       dac_out;
  logic [6:0] level;
  logic       active;

  modport master (
    output snd,
    output mute,
    input  dac_out,
    input  level,
    input  active
  );

  modport slave (
    input  snd,
    input  mute,
    output dac_out,
    output level,
    output active
  );
endinterface

// File: rtl/snd_dac.sv
// Sound DAC: slew-limited level controller with mute ramping, followed by
// a first-order 1-bit pulse-density modulator driving an external RC filter.
module snd_dac #(
  parameter int unsigned TICK_DIV = 64
) (
  input  logic  clk,
  input  logic  reset_l,
  snd_dac_if.slave bus
);

  typedef enum logic [1:0] {
    ST_MUTED     = 2'd0,
    ST_RAMP      = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TICK_DIV - 1);

  logic [6:0] snd_q,    snd_d;
  logic       mute_q,   mute_d;
  logic [7:0] cnt_q,    cnt_d;
  state_e     state_q,  state_d;
  logic [6:0] level_q,  level_d;
  logic [6:0] acc_q,    acc_d;
  logic       dac_q,    dac_d;
  logic       active_q, active_d;
  logic       tick_s;
  logic [7:0] sum_s;

  // Input capture: every FSM decision is taken from these registered copies.
  always_comb begin
    snd_d  = bus.snd;
    mute_d = bus.mute;
  end

  // Tick divider: tick fires on the last count of each TICK_DIV-cycle period.
  always_comb begin
    tick_s = (cnt_q == CNT_LAST);
    if (tick_s) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Level FSM: state and level only move on tick cycles.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (tick_s) begin
      case (state_q)
        ST_MUTED: begin
          level_d = 7'd0;
          if (!mute_q) begin
            state_d = ST_RAMP;
          end else begin
            state_d = ST_MUTED;
          end
        end
        ST_RAMP: begin
          if (mute_q) begin
            state_d = ST_RAMP_DOWN;
          end else if (level_q == snd_q) begin
            state_d = ST_RUN;
          end else if (level_q < snd_q) begin
            level_d = level_q + 7'd1;
          end else begin
            level_d = level_q - 7'd1;
          end
        end
        ST_RUN: begin
          if (mute_q) begin
            state_d = ST_RAMP_DOWN;
          end else begin
            level_d = snd_q;
          end
        end
        ST_RAMP_DOWN: begin
          if (!mute_q) begin
            state_d = ST_RAMP;
          end else if (level_q == 7'd0) begin
            state_d = ST_MUTED;
          end else begin
            level_d = level_q - 7'd1;
          end
        end
        default: begin
          state_d = ST_MUTED;
          level_d = 7'd0;
        end
      endcase
    end else begin
      state_d = state_q;
      level_d = level_q;
    end
    active_d = (state_d == ST_RUN);
  end

  // Modulator: the carry out of the accumulator is the output bit, so the
  // ones density equals level/128 exactly; uses the already-registered level.
  always_comb begin
    sum_s = {1'b0, acc_q} + {1'b0, level_q};
    acc_d = sum_s[6:0];
    dac_d = sum_s[7];
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      snd_q    <= 7'd0;
      mute_q   <= 1'b1;
      cnt_q    <= 8'd0;
      state_q  <= ST_MUTED;
      level_q  <= 7'd0;
      acc_q    <= 7'd0;
      dac_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      snd_q    <= snd_d;
      mute_q   <= mute_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      level_q  <= level_d;
      acc_q    <= acc_d;
      dac_q    <= dac_d;
      active_q <= active_d;
    end
  end

  assign bus.dac_out = dac_q;
  assign bus.level   = level_q;
  assign bus.active  = active_q;

endmodule

// File: tb/tb_snd_dac.sv
// Self-checking bench for snd_dac: a cycle model pushes expected outputs to
// a queue at each edge; they are popped and compared on the falling edge.
module tb_snd_dac;

  localparam int TD = 64;
  localparam int S_MUTED = 0, S_RAMP = 1, S_RUN = 2, S_RDOWN = 3;

  logic clk;
  logic reset_l;
  snd_dac_if bus ();

  snd_dac #(.TICK_DIV(TD)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ones   = 0;
  int cur_s  = 0;
  int cur_m  = 1;
  logic [8:0] exp_q[$];

  int m_snd_q, m_mute_q, m_cnt, m_state, m_level, m_acc, m_dac, m_active;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour of one rising edge, from the model's current values.
  task automatic model_edge(input logic r, input int s, input int m);
    int  n_state, n_level, sum;
    bit  tk;
    if (!r) begin
      m_snd_q = 0; m_mute_q = 1; m_cnt = 0; m_state = S_MUTED;
      m_level = 0; m_acc = 0; m_dac = 0; m_active = 0;
      return;
    end
    tk      = (m_cnt == TD - 1);
    sum     = m_acc + m_level;
    n_state = m_state;
    n_level = m_level;
    if (tk) begin
      case (m_state)
        S_MUTED: if (m_mute_q == 0) n_state = S_RAMP;
        S_RAMP: begin
          if (m_mute_q == 1) n_state = S_RDOWN;
          else if (m_level == m_snd_q) n_state = S_RUN;
          else if (m_snd_q > m_level) n_level = m_level + 1;
          else n_level = m_level - 1;
        end
        S_RUN: begin
          if (m_mute_q == 1) n_state = S_RDOWN;
          else n_level = m_snd_q;
        end
        default: begin
          if (m_mute_q == 0) n_state = S_RAMP;
          else if (m_level == 0) n_state = S_MUTED;
          else n_level = m_level - 1;
        end
      endcase
    end
    m_dac    = sum / 128;
    m_acc    = sum % 128;
    m_cnt    = tk ? 0 : m_cnt + 1;
    m_state  = n_state;
    m_level  = n_level;
    m_active = (n_state == S_RUN) ? 1 : 0;
    m_snd_q  = s;
    m_mute_q = m;
  endtask

  task automatic cyc(input logic r, input int s, input int m);
    logic [8:0] e;
    logic [8:0] o;
    logic [6:0] lv;
    reset_l  = r;
    bus.snd  = 7'(s);
    bus.mute = (m != 0);
    @(posedge clk);
    model_edge(r, s, m);
    lv = 7'(m_level);
    exp_q.push_back({(m_dac != 0), lv, (m_active != 0)});
    @(negedge clk);
    e = exp_q.pop_front();
    o = {bus.dac_out, bus.level, bus.active};
    check_val("cycle{dac,level,active}", 32'(o), 32'(e));
    if (bus.dac_out === 1'b1) ones++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, cur_s, cur_m);
  endtask

  initial begin
    int n, bad, mn, pair;
    reset_l  = 1'b0;
    bus.snd  = 7'd0;
    bus.mute = 1'b1;
    @(negedge clk);
    cyc(1'b0, 0, 1);
    cyc(1'b0, 0, 1);
    check_val("rst_level",  32'(bus.level),   32'd0);
    check_val("rst_active", 32'(bus.active),  32'd0);
    check_val("rst_dac",    32'(bus.dac_out), 32'd0);
    check_val("rst_cnt",    32'(dut.cnt_q),   32'd0);
    check_val("rst_acc",    32'(dut.acc_q),   32'd0);

    // Full ramp 0 -> 127 from reset.
    cur_s = 127; cur_m = 0;
    run(TD);
    check_val("tick1_state", 32'(dut.state_q), 32'd1);
    check_val("tick1_level", 32'(bus.level), 32'd0);
    run(TD);
    check_val("tick2_level", 32'(bus.level), 32'd1);
    run(126 * TD);
    check_val("tick128_level",  32'(bus.level),  32'd127);
    check_val("tick128_active", 32'(bus.active), 32'd0);
    run(TD);
    check_val("tick129_active", 32'(bus.active), 32'd1);
    check_val("tick129_level",  32'(bus.level),  32'd127);

    // Modulator density at level 64, 127 and 0.
    cur_s = 64;
    run(2 * TD);
    check_val("run64_level", 32'(bus.level), 32'd64);
    for (int k = 0; k < 4; k++) begin
      ones = 0;
      run(2);
      check_val("alt_pair_ones", 32'(ones), 32'd1);
    end
    ones = 0; run(128);
    check_val("ones_64", 32'(ones), 32'd64);
    cur_s = 127;
    run(2 * TD);
    ones = 0; run(128);
    check_val("ones_127", 32'(ones), 32'd127);
    cur_s = 0;
    run(2 * TD);
    ones = 0; run(128);
    check_val("ones_0", 32'(ones), 32'd0);

    // Step 20 -> 100 in RUN: single jump, bounded latency.
    cur_s = 20;
    run(2 * TD);
    check_val("run20_level", 32'(bus.level), 32'd20);
    cur_s = 100; n = 0; bad = 0;
    while (bus.level !== 7'd100 && n < TD + 5) begin
      run(1); n++;
      if (bus.level !== 7'd20 && bus.level !== 7'd100) bad++;
    end
    check_val("step_no_intermediate", 32'(bad), 32'd0);
    check_val("step_latency_ok", 32'(n >= 2 && n <= TD + 1), 32'd1);
    check_val("step_level", 32'(bus.level), 32'd100);

    // Mute from level 10: ramp down to MUTED, output silent.
    cur_s = 10;
    run(2 * TD);
    check_val("run10_level", 32'(bus.level), 32'd10);
    cur_m = 1; n = 0;
    while (m_state != S_MUTED && n < 15 * TD) begin run(1); n++; end
    check_val("rdown_reached_muted", 32'(n < 15 * TD), 32'd1);
    check_val("rdown_time_ok", 32'(n > 11 * TD && n <= 13 * TD), 32'd1);
    check_val("muted_level",  32'(bus.level),  32'd0);
    check_val("muted_active", 32'(bus.active), 32'd0);
    ones = 0; run(128);
    check_val("muted_ones", 32'(ones), 32'd0);

    // Unmute during RAMP_DOWN at level 40 returns to RUN without losing level.
    cur_m = 0; cur_s = 40; n = 0;
    while (!(m_state == S_RUN && m_level == 40) && n < 45 * TD) begin run(1); n++; end
    check_val("run40_reached", 32'(n < 45 * TD), 32'd1);
    cur_m = 1; n = 0;
    while (m_state != S_RDOWN && n < 2 * TD + 2) begin run(1); n++; end
    check_val("rdown40_reached", 32'(n < 2 * TD + 2), 32'd1);
    check_val("rdown40_active", 32'(bus.active), 32'd0);
    check_val("rdown40_level",  32'(bus.level),  32'd40);
    cur_m = 0; mn = 127;
    for (int k = 0; k < 2 * TD; k++) begin
      run(1);
      if (int'(bus.level) < mn) mn = int'(bus.level);
    end
    check_val("unmute_min_level", 32'(mn), 32'd40);
    check_val("unmute_level",  32'(bus.level),  32'd40);
    check_val("unmute_active", 32'(bus.active), 32'd1);

    // One-cycle reset mid-period while running at level 50.
    cur_s = 50;
    run(2 * TD);
    check_val("run50_level", 32'(bus.level), 32'd50);
    n = 0;
    while (m_cnt != 30 && n < TD + 2) begin run(1); n++; end
    check_val("cnt30_reached", 32'(n < TD + 2), 32'd1);
    cyc(1'b0, cur_s, cur_m);
    check_val("mid_rst_level",  32'(bus.level),   32'd0);
    check_val("mid_rst_acc",    32'(dut.acc_q),   32'd0);
    check_val("mid_rst_dac",    32'(bus.dac_out), 32'd0);
    check_val("mid_rst_state",  32'(dut.state_q), 32'd0);
    check_val("mid_rst_cnt",    32'(dut.cnt_q),   32'd0);
    check_val("mid_rst_active", 32'(bus.active),  32'd0);

    // First tick after reset: TICK_DIV cycles later, leaves MUTED only if unmuted.
    cur_m = 1;
    run(TD);
    check_val("first_tick_muted_stays", 32'(dut.state_q), 32'd0);
    cyc(1'b0, cur_s, cur_m);
    cur_m = 0;
    run(TD - 1);
    pair = int'(dut.state_q);
    check_val("before_first_tick_state", 32'(pair), 32'd0);
    run(1);
    check_val("first_tick_state", 32'(dut.state_q), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snd_dac.md
SND_DAC -- requirements
Module: snd_dac

Interface
REQ-001 Parameter TICK_DIV, default 64: number of clk cycles per level-update tick, legal range 2..256.
REQ-002 clk  input  1  sound clock (14.318 MHz), the only clock; all state updates on its rising edge.
REQ-003 reset_l  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 snd  input  7  unsigned sample from the sound generator, 0..127, may change on any cycle.
REQ-005 mute  input  1  request to ramp the output to silence; level-sensitive.
REQ-006 dac_out  output  1  registered 1-bit pulse-density stream feeding the external RC filter.
REQ-007 level  output  7  registered current modulator level, for observation.
REQ-008 active  output  1  registered, high only while the FSM is in RUN.

Function
REQ-009 snd and mute SHALL each be registered every clk cycle into snd_q and mute_q; all FSM decisions use only snd_q and mute_q.
REQ-010 Tick counter: 0..TICK_DIV-1, increments every cycle, wraps to 0; tick is asserted in the cycle where counter == TICK_DIV-1.
REQ-011 FSM states: MUTED, RAMP, RUN, RAMP_DOWN; transitions and level changes occur only in tick cycles.
REQ-012 MUTED: level held at 0; on tick with mute_q=0 -> RAMP, level unchanged on that tick.
REQ-013 RAMP on tick: if mute_q=1 -> RAMP_DOWN with level unchanged; else if level == snd_q -> RUN; else level moves 1 toward snd_q.
REQ-014 RUN on tick: if mute_q=1 -> RAMP_DOWN with level unchanged; else level <= snd_q, with no slew limit.
REQ-015 RAMP_DOWN on tick: if mute_q=0 -> RAMP; else if level == 0 -> MUTED; else level decrements by 1.
REQ-016 Modulator: 7-bit accumulator acc; every clk cycle, 8-bit sum = acc + level; dac_out <= sum[7]; acc <= sum[6:0].
REQ-017 The ones density of dac_out SHALL be exactly level/128 over any 128 consecutive cycles at constant level; level 0 gives a constant 0.
REQ-018 The modulator SHALL use the level value registered before the current edge, so a level change affects dac_out one cycle later.
REQ-019 active <= 1 on the same edge the FSM enters RUN; active <= 0 on the same edge it leaves RUN.
REQ-020 Latency from a snd change to level in RUN: 1 cycle for snd_q, then the next tick; the maximum is TICK_DIV+1 cycles.
REQ-021 A mute change coincident with a tick cycle SHALL take effect at the following tick, because mute_q lags mute by one cycle.
REQ-022 No arithmetic overflow is permitted: ramps stop at snd_q or at 0, and the accumulator carry is the output bit.

Reset
REQ-023 When reset_l=0 at a clk edge, the following SHALL be set on that edge, regardless of state or tick phase:
- state=MUTED, level=0, acc=0, counter=0
- dac_out=0, active=0
- snd_q=0, mute_q=1
REQ-024 After reset_l returns high, the first tick SHALL occur TICK_DIV cycles later.
REQ-025 The first tick after reset SHALL leave MUTED only if mute_q=0.

Verification
REQ-026 Reset; mute=0, snd=127 -> RAMP at tick 1; level=1..127 on ticks 2..128; RUN and active=1 at tick 129.
REQ-027 Ramp a step input in RUN:
- setup: RUN at level 64
- dac_out: alternates 0,1,0,1 with acc alternating 64,0
- then snd=127: exactly 127 ones per 128-cycle window
- then snd=0: constant 0 after the level update
REQ-028 RUN at level 10, then mute=1 -> RAMP_DOWN at the next tick; level 9..0 over 10 ticks; MUTED on the following tick; active=0; dac_out stays 0.
REQ-029 RUN, snd stepped 20->100 -> level=100 at the first tick at least 2 cycles after the step, with no intermediate values.
REQ-030 RUN at level 50, reset_l=0 for one cycle at counter=30 -> the next cycle shows level=0, acc=0, dac_out=0, state MUTED, counter=0.
REQ-031 RAMP_DOWN at level 40, mute deasserted with snd=40 -> RAMP at the next tick; RUN at the following tick with level=40.
